// File: rtl/image_loader.sv
// Writer side of the classifier input buffer: syncs on a header byte, writes one frame
// of int8 pixels, then starts inference and waits. Optional IMAGE_LOADER_CENTER_EN centers pixels.
module image_loader #(
    parameter int          IN_DIM    = 784,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    input  logic [7:0]                s_data,
    output logic                      s_ready,
    output logic                      x_we,
    output logic [$clog2(IN_DIM)-1:0] x_addr,
    output logic [7:0]                x_data,
    output logic                      infer_start,
    input  logic                      infer_done,
    output logic                      busy,
    output logic [CNT_W-1:0]          frames_loaded
);
    // state  | meaning
    // IDLE   | hunting for SYNC_BYTE, other bytes dropped
    // LOAD   | each accepted byte is a pixel, written the following cycle
    // FLUSH  | final pixel write in flight, input blocked
    // START  | one-cycle inference request
    // WAIT   | inference running, waiting for infer_done
    localparam int AW = $clog2(IN_DIM);
    localparam logic [AW-1:0] LAST_IDX = AW'(IN_DIM - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_START, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic             accept;
    logic [7:0]       pixel;

    assign accept = s_valid && s_ready;

`ifdef IMAGE_LOADER_CENTER_EN
    assign pixel = {~s_data[7], s_data[6:0]};
`else
    assign pixel = s_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            frames_q <= frames_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        frames_d = frames_q;
        case (state_q)
            S_IDLE: begin
                if (accept && s_data == SYNC_BYTE) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d   = 1'b1;
                    addr_d = idx_q;
                    data_d = pixel;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FLUSH;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            S_FLUSH: state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (infer_done) begin
                    state_d  = S_IDLE;
                    frames_d = frames_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        s_ready     = (state_q == S_IDLE) || (state_q == S_LOAD);
        infer_start = (state_q == S_START);
    end

    assign x_we          = we_q;
    assign x_addr        = addr_q;
    assign x_data        = data_q;
    assign busy          = busy_q;
    assign frames_loaded = frames_q;

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader with IN_DIM=4, CNT_W=2: expected writes are queued
// by the stimulus and popped by a write monitor.
module tb_image_loader;
    localparam int IN_DIM = 4;
    localparam int CNT_W  = 2;
    localparam int AW     = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_ready;
    logic          x_we;
    logic [AW-1:0] x_addr;
    logic [7:0]    x_data;
    logic          infer_start;
    logic          infer_done = 1'b0;
    logic          busy;
    logic [CNT_W-1:0] frames_loaded;

    image_loader #(.IN_DIM(IN_DIM), .SYNC_BYTE(8'hA5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .x_we(x_we), .x_addr(x_addr), .x_data(x_data), .infer_start(infer_start),
        .infer_done(infer_done), .busy(busy), .frames_loaded(frames_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int start_cnt = 0;
    logic [AW+7:0] exp_q[$];
    logic prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] conv(input logic [7:0] b);
`ifdef IMAGE_LOADER_CENTER_EN
        return b ^ 8'h80;
`else
        return b;
`endif
    endfunction

    // Write / start monitor
    always @(negedge clk) begin
        if (x_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {22'd0, x_addr, x_data}, 32'hFFFF_FFFF);
            end else begin
                logic [AW+7:0] e;
                e = exp_q.pop_front();
                check("write_addr_data", {22'd0, x_addr, x_data}, {22'd0, e});
            end
        end
        if (infer_start) begin
            start_cnt++;
            check("start_after_last_write", {31'd0, prev_we && prev_addr == AW'(IN_DIM - 1)}, 32'd1);
        end
        prev_we   = x_we;
        prev_addr = x_addr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (!s_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("send_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic send_pixels(input logic [7:0] p0, p1, p2, p3, input int gaps);
        logic [7:0] p[4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({AW'(i), conv(p[i])});
            send_byte(p[i]);
            if (gaps != 0) begin
                s_valid = 1'b0;
                repeat ((i % 3) + 1) step();
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_start(input int prev);
        int n;
        n = 0;
        while (start_cnt == prev && n < 30) begin
            step();
            n++;
        end
        if (n >= 30) check("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_done();
        infer_done = 1'b1;
        step();
        infer_done = 1'b0;
    endtask

    initial begin
        int s0, w0, rdy;
        repeat (3) step();
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_x_we", {31'd0, x_we}, 32'd0);
        check("rst_x_addr", {30'd0, x_addr}, 32'd0);
        check("rst_x_data", {24'd0, x_data}, 32'd0);
        check("rst_start", {31'd0, infer_start}, 32'd0);
        check("rst_frames", {30'd0, frames_loaded}, 32'd0);
        rst = 1'b0;
        step();

        // Continuous frame
        s0 = start_cnt;
        send_pixels(8'h10, 8'h20, 8'h30, 8'h40, 0);
        wait_start(s0);
        step();
        check("wait_s_ready", {31'd0, s_ready}, 32'd0);
        check("wait_busy", {31'd0, busy}, 32'd1);
        check("one_start_f1", start_cnt - s0, 32'd1);

        // Input held during WAIT must be blocked
        s_valid = 1'b1;
        s_data  = 8'h55;
        rdy = 0;
        w0 = wr_cnt;
        for (int i = 0; i < 20; i++) begin
            if (s_ready) rdy++;
            step();
        end
        check("wait_ready_cycles", rdy, 32'd0);
        check("wait_no_writes", wr_cnt - w0, 32'd0);
        pulse_done();
        check("idle_s_ready", {31'd0, s_ready}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("frames_1", {30'd0, frames_loaded}, 32'd1);
        step();
        s_valid = 1'b0;

        // Junk before sync, in-frame sync byte is data
        send_byte(8'h00);
        send_byte(8'hFF);
        s0 = start_cnt;
        send_pixels(8'h01, 8'hA5, 8'h02, 8'h03, 0);
        wait_start(s0);
        step();
        pulse_done();
        check("frames_2", {30'd0, frames_loaded}, 32'd2);

        // infer_done ignored in IDLE and LOAD, with input gaps
        pulse_done();
        check("done_in_idle", {30'd0, frames_loaded}, 32'd2);
        s0 = start_cnt;
        send_byte(8'hA5);
        s_valid = 1'b0;
        pulse_done();
        check("done_in_load", {30'd0, frames_loaded}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({AW'(i), conv(8'hC0 + 8'(i))});
            send_byte(8'hC0 + 8'(i));
            s_valid = 1'b0;
            repeat (i + 1) step();
        end
        wait_start(s0);
        step();
        pulse_done();
        check("frames_3", {30'd0, frames_loaded}, 32'd3);

        // Reset after two pixels; third byte arrives with reset and is dropped
        send_byte(8'hA5);
        exp_q.push_back({AW'(0), conv(8'h11)});
        exp_q.push_back({AW'(1), conv(8'h22)});
        send_byte(8'h11);
        send_byte(8'h22);
        s_data = 8'h33;
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_valid = 1'b0;
        check("rst_drop_we", {31'd0, x_we}, 32'd0);
        check("rst_frames0", {30'd0, frames_loaded}, 32'd0);
        check("rst_queue_drained", exp_q.size(), 32'd0);
        step();
        s0 = start_cnt;
        w0 = wr_cnt;
        send_pixels(8'h61, 8'h62, 8'h63, 8'h64, 1);
        wait_start(s0);
        step();
        check("post_rst_writes", wr_cnt - w0, 32'd4);
        check("post_rst_one_start", start_cnt - s0, 32'd1);
        pulse_done();
        check("frames_after_rst", {30'd0, frames_loaded}, 32'd1);

        // Centering boundary bytes plus counter wrap
        s0 = start_cnt;
        send_pixels(8'h00, 8'h80, 8'hFF, 8'h7F, 0);
        wait_start(s0);
        step();
        pulse_done();
        for (int f = 0; f < 2; f++) begin
            s0 = start_cnt;
            send_pixels(8'(f), 8'h5A, 8'hA5, 8'h81, 0);
            wait_start(s0);
            step();
            pulse_done();
        end
        check("frames_wrap", {30'd0, frames_loaded}, 32'd0);
        repeat (3) step();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
